// File: rtl/apb_mem_slave.sv
// APB4 completer fronting a word-organised, byte-enabled storage array with
// configurable wait states, decode/alignment/secure-region faults and a fault counter.
module apb_mem_slave #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    DEPTH        = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
  parameter int                    WAIT_STATES  = 0,
  parameter int                    SECURE_START = DEPTH
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic [2:0]              pprot,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr,
  output logic [15:0]             err_count
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int BYTE_LSB = $clog2(STRB_W);
  localparam int IDX_W    = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB_W - 1);
  localparam logic [IDX_W:0]        SEC_IDX    = (IDX_W + 1)'(SECURE_START);
  localparam logic [3:0]            WAIT_INIT  = 4'(WAIT_STATES);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACCESS = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [3:0]            wait_q, wait_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     strb_q, strb_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic [15:0]           err_count_q, err_count_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Decode is done on the live bus only at setup; the offset is meaningful only
  // when paddr >= BASE_ADDR, so an address below the base never aliases.
  logic [ADDR_WIDTH-1:0] offset;
  logic [IDX_W-1:0]      setup_idx;
  logic                  setup_err;
  logic                  pready_w;
  logic                  complete;
  logic                  mem_we;

  assign offset    = paddr - BASE_ADDR;
  assign setup_idx = offset[BYTE_LSB +: IDX_W];
  assign setup_err = (paddr < BASE_ADDR)
                   || (|(offset >> (BYTE_LSB + IDX_W)))
                   || (|(offset & ALIGN_MASK))
                   || (pprot[1] && ({1'b0, setup_idx} >= SEC_IDX));

  assign pready_w = (state_q == S_ACCESS) && (wait_q == 4'd0);
  assign complete = pready_w && psel && penable;
  assign mem_we   = complete && write_q && !err_q && !preset;

  // NOTE: every signal written here gets a default first, so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    idx_d       = idx_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    strb_d      = strb_q;
    err_d       = err_q;
    prdata_d    = prdata_q;
    err_count_d = err_count_q;
    case (state_q)
      S_IDLE: begin
        if (psel && !penable) begin
          state_d  = S_ACCESS;
          wait_d   = WAIT_INIT;
          idx_d    = setup_idx;
          write_d  = pwrite;
          wdata_d  = pwdata;
          strb_d   = pstrb;
          err_d    = setup_err;
          prdata_d = (!setup_err && !pwrite) ? mem[setup_idx] : '0;
        end
      end
      default: begin
        if (!psel) begin
          state_d = S_IDLE;
        end else if (penable) begin
          if (wait_q != 4'd0) begin
            wait_d = wait_q - 4'd1;
          end else begin
            state_d = S_IDLE;
            if (err_q && (err_count_q != 16'hFFFF)) begin
              err_count_d = err_count_q + 16'd1;
            end
          end
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q     <= S_IDLE;
      wait_q      <= 4'd0;
      idx_q       <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      strb_q      <= '0;
      err_q       <= 1'b0;
      prdata_q    <= '0;
      err_count_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      idx_q       <= idx_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      strb_q      <= strb_d;
      err_q       <= err_d;
      prdata_q    <= prdata_d;
      err_count_q <= err_count_d;
    end
  end

  // NOTE: the storage array has no reset, which keeps it mappable onto plain RAM.
  always_ff @(posedge pclk) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (strb_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign prdata    = prdata_q;
  assign pready    = pready_w;
  assign pslverr   = err_q & pready_w;
  assign err_count = err_count_q;

endmodule

// File: doc/apb_mem_slave.md
Name: apb_mem_slave

Overview:
Parametrised APB4 completer that places a byte-addressable, word-organised storage array on the peripheral bus. It supports configurable data width, depth, base address and wait states, honours pstrb byte enables, and returns pslverr on decode, alignment and protection faults. It also keeps a saturating fault counter. It is the standard target behind the team's APB interface for register-file and scratch-memory endpoints, and is the DUT for slave-side agent testing.

Parameters:
ADDR_WIDTH, 32, width of paddr
DATA_WIDTH, 32, width of pwdata/prdata; legal values 8, 16, 32, 64
DEPTH, 256, number of DATA_WIDTH words; power of two, >= 2
BASE_ADDR, 0, byte address of word 0; aligned to DEPTH*DATA_WIDTH/8
WAIT_STATES, 0, access-phase cycles with pready low before completion; 0..15
SECURE_START, DEPTH, first word index of the secure region (DEPTH = no secure region)

Ports:
pclk  in  1  bus clock; all state on rising edge
preset  in  1  asynchronous, active-high reset
psel  in  1  select
penable  in  1  access-phase strobe
pwrite  in  1  1 = write, 0 = read
paddr  in  ADDR_WIDTH  byte address
pwdata  in  DATA_WIDTH  write data
pstrb  in  DATA_WIDTH/8  write byte enables
pprot  in  3  protection; bit1 = 1 means non-secure
prdata  out  DATA_WIDTH  read data; valid while pready=1 on a read
pready  out  1  transfer completion
pslverr  out  1  error response; valid while pready=1
err_count  out  16  saturating count of completed transfers with pslverr=1

Behaviour:
- Reset (preset=1, asynchronous): state IDLE, wait counter 0, prdata=0, pready=0, pslverr=0, err_count=0. Storage contents are not reset.
- FSM states are IDLE and ACCESS.
- IDLE -> ACCESS on the edge where psel=1 and penable=0 (setup). That edge does the following:
  - latches paddr, pwrite, pwdata, pstrb and pprot;
  - loads the wait counter with WAIT_STATES;
  - evaluates the error, and sets prdata = mem[idx] for an error-free read, otherwise prdata = 0.
- In IDLE, penable=1 without a prior setup is ignored.
- ACCESS behaviour:
  - pready = (wait counter == 0). This is the only state where pready can be 1.
  - pslverr = latched error AND pready.
  - The counter decrements each cycle while it is nonzero and psel=penable=1.
- Completion edge (ACCESS, psel=1, penable=1, pready=1):
  - for an error-free write, updates byte lanes of mem[idx] where pstrb[i]=1 (pstrb all-zero writes nothing; still OKAY);
  - increments err_count if pslverr=1 (saturates at 0xFFFF);
  - returns to IDLE.
- Latency:
  - WAIT_STATES=0 gives the classic two-cycle transfer (setup, access).
  - Otherwise the transfer takes 2+WAIT_STATES cycles.
- Back-to-back: the cycle after completion may be a new setup. No idle cycle is required.
- Error is set if any of the following holds:
  - (a) paddr < BASE_ADDR or paddr >= BASE_ADDR + DEPTH*DATA_WIDTH/8;
  - (b) paddr low log2(DATA_WIDTH/8) bits are nonzero;
  - (c) pprot[1]=1 and idx >= SECURE_START.
- idx = (paddr - BASE_ADDR) >> log2(DATA_WIDTH/8). All arithmetic is done at ADDR_WIDTH bits with no wrap, so an address below BASE_ADDR is an error, not an alias.
- Erroneous transfers never modify storage and return prdata=0.
- Abort: psel=0 while in ACCESS returns the FSM to IDLE next edge. The access is treated as not having occurred: no write and no err_count change.
- Reset mid-transfer: the FSM goes to IDLE immediately and the pending write is discarded.
- Inputs and paddr are not re-sampled during ACCESS. Changes to them mid-access do not alter the transfer.

Test Plan:
1. DATA_WIDTH=32, DEPTH=16, BASE_ADDR=0x1000, WAIT_STATES=0: write 0xDEADBEEF to 0x1008 with pstrb=0xF, then read 0x1008 -> each transfer takes 2 cycles, pslverr=0, prdata=0xDEADBEEF.
2. Same config: write 0x11223344 to 0x1008 with pstrb=0x5, then read -> prdata=0xDE22BE44.
3. WAIT_STATES=3: read 0x1000 -> pready low for 3 access cycles and high on the 4th; total 5 cycles; back-to-back second read completes with no idle gap.
4. Reads at 0x0FFC, 0x1040 and 0x1002 -> pslverr=1, prdata=0, err_count increments 1,2,3. A following write to 0x1040 leaves storage unchanged.
5. SECURE_START=8: write to 0x1020 with pprot=3'b010 -> pslverr=1 and mem[8] unchanged; the same write with pprot=3'b000 -> OKAY and the data lands.
6. Drop psel mid-wait (WAIT_STATES=3) on a write to 0x1004 -> FSM returns to IDLE, mem[1] unchanged, err_count unchanged. Assert preset during a different access -> pready=0, prdata=0, err_count=0 immediately.
